// File: rtl/audio_pkg.sv
// audio_pkg: register map, status bit positions, FSM states and frame type
// shared by the audio sample sink and its I2S serializer.
package audio_pkg;

  localparam logic [31:0] ADDR_LEFT   = 32'h1000_0010;
  localparam logic [31:0] ADDR_RIGHT  = 32'h1000_0020;
  localparam logic [31:0] ADDR_STATUS = 32'h1000_0040;

  localparam int BIT_PLAYING  = 16;
  localparam int BIT_UNDERRUN = 17;
  localparam int BIT_PAIR_ERR = 18;
  localparam int BIT_UCOUNT   = 24;

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_PLAYING = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } frame_t;

endpackage

// File: rtl/audio_sample_sink_if.sv
// audio_sample_sink_if: LSU data-bus command/response channel used by the
// audio sample sink (master = CPU side, slave = peripheral side).
interface audio_sample_sink_if;
  logic        bus_cmd_valid;
  logic        bus_cmd_ready;
  logic        bus_cmd_write;
  logic [31:0] bus_cmd_address;
  logic [31:0] bus_cmd_data;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;

  modport master (
    output bus_cmd_valid, bus_cmd_write, bus_cmd_address, bus_cmd_data,
    input  bus_cmd_ready, bus_rsp_valid, bus_rsp_data
  );

  modport slave (
    input  bus_cmd_valid, bus_cmd_write, bus_cmd_address, bus_cmd_data,
    output bus_cmd_ready, bus_rsp_valid, bus_rsp_data
  );
endinterface

// File: rtl/audio_i2s_serializer.sv
// audio_i2s_serializer: shifts one 32-bit stereo frame out MSB first with a
// 20-clock bit period (left word lrclk=0, right word lrclk=1), then idles low.
module audio_i2s_serializer
  import audio_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  frame_t frame,
  output logic   bclk,
  output logic   lrclk,
  output logic   sdata
);

  localparam logic [4:0] PHASE_RISE = 5'd9;
  localparam logic [4:0] PHASE_LAST = 5'd19;
  localparam logic [4:0] BIT_LAST   = 5'd31;
  localparam logic [4:0] BIT_LEFT_LAST = 5'd15;

  logic        active;
  logic [4:0]  phase;
  logic [4:0]  bit_idx;
  logic [31:0] shreg;

  // Outputs are loaded on the start edge so the first bit shares the strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      phase   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= '0;
      bit_idx <= '0;
      shreg   <= frame;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      sdata   <= frame.l[15];
    end else if (active) begin
      if (phase == PHASE_LAST) begin
        phase <= '0;
        bclk  <= 1'b0;
        if (bit_idx == BIT_LAST) begin
          active <= 1'b0;
          lrclk  <= 1'b0;
          sdata  <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 1'b1;
          shreg   <= {shreg[30:0], 1'b0};
          sdata   <= shreg[30];
          lrclk   <= (bit_idx >= BIT_LEFT_LAST);
        end
      end else begin
        phase <= phase + 1'b1;
        if (phase == PHASE_RISE) bclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_sample_sink.sv
// audio_sample_sink: pairs left/right PCM writes into a frame FIFO and plays
// one frame per TICKS_PER_SAMPLE clocks after prefill; I2S output with AUDIO_I2S_EN.
module audio_sample_sink
  import audio_pkg::*;
#(
  parameter int TICKS_PER_SAMPLE = 680,
  parameter int FIFO_DEPTH       = 64,
  parameter int START_LEVEL      = 40
) (
  input  logic               clk,
  input  logic               reset,
  audio_sample_sink_if.slave lsu,
  output logic               sample_strobe,
  output logic [15:0]        sample_left,
  output logic [15:0]        sample_right,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TCK_W = $clog2(TICKS_PER_SAMPLE);

  localparam logic [LVL_W-1:0] START_LVL = LVL_W'(START_LEVEL);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(TICKS_PER_SAMPLE - 1);

  state_t           state;
  logic [TCK_W-1:0] tick;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [15:0]      hold;
  logic             hold_valid;
  logic             pair_error;
  logic             underrun_sticky;
  logic [7:0]       ucount;

  frame_t mem [FIFO_DEPTH];
  frame_t head;
  frame_t push_frame;

  logic        hit_left, hit_right, hit_status;
  logic        right_req, cmd_ready, accept, push, pop;
  logic        fifo_empty, fifo_full, frame_fire;
  logic [31:0] status;
  logic        unused_data;

  assign hit_left   = (lsu.bus_cmd_address == ADDR_LEFT);
  assign hit_right  = (lsu.bus_cmd_address == ADDR_RIGHT);
  assign hit_status = (lsu.bus_cmd_address == ADDR_STATUS);

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);
  assign head       = mem[rd_ptr];

  // A frame slot comes due on PREFILL exit and every wrap of the tick counter.
  assign frame_fire = (state == ST_PREFILL) ? ((level >= START_LVL) && !fifo_empty)
                                            : (tick == TICK_LAST);
  assign pop        = frame_fire && !fifo_empty;

  assign right_req         = lsu.bus_cmd_valid && lsu.bus_cmd_write && hit_right;
  assign cmd_ready         = !(right_req && fifo_full && !pop);
  assign lsu.bus_cmd_ready = cmd_ready;
  assign accept            = lsu.bus_cmd_valid && cmd_ready;
  assign push              = accept && lsu.bus_cmd_write && hit_right;
  assign unused_data       = ^lsu.bus_cmd_data[31:16];

  always_comb begin
    push_frame   = '0;
    push_frame.l = hold_valid ? hold : '0;
    push_frame.r = lsu.bus_cmd_data[15:0];
  end

  always_comb begin
    status                     = '0;
    status[15:0]               = 16'(level);
    status[BIT_PLAYING]        = (state == ST_PLAYING);
    status[BIT_UNDERRUN]       = underrun_sticky;
    status[BIT_PAIR_ERR]       = pair_error;
    status[BIT_UCOUNT +: 8]    = ucount;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_frame;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_PREFILL;
      tick              <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      hold              <= '0;
      hold_valid        <= 1'b0;
      pair_error        <= 1'b0;
      underrun_sticky   <= 1'b0;
      ucount            <= '0;
      lsu.bus_rsp_valid <= 1'b0;
      lsu.bus_rsp_data  <= '0;
      sample_strobe     <= 1'b0;
      sample_left       <= '0;
      sample_right      <= '0;
    end else begin
      lsu.bus_rsp_valid <= accept;
      if (accept)
        lsu.bus_rsp_data <= (!lsu.bus_cmd_write && hit_status) ? status : '0;

      if (accept && lsu.bus_cmd_write) begin
        if (hit_left) begin
          hold       <= lsu.bus_cmd_data[15:0];
          hold_valid <= 1'b1;
          if (hold_valid) pair_error <= 1'b1;
        end
        if (hit_right) begin
          hold_valid <= 1'b0;
          if (!hold_valid) pair_error <= 1'b1;
        end
        if (hit_status) begin
          ucount          <= '0;
          underrun_sticky <= 1'b0;
          pair_error      <= 1'b0;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      sample_strobe <= 1'b0;
      case (state)
        ST_PREFILL: begin
          if (frame_fire) begin
            state         <= ST_PLAYING;
            tick          <= '0;
            sample_strobe <= 1'b1;
            sample_left   <= head.l;
            sample_right  <= head.r;
          end
        end
        ST_PLAYING: begin
          if (frame_fire) begin
            tick <= '0;
            if (!fifo_empty) begin
              sample_strobe <= 1'b1;
              sample_left   <= head.l;
              sample_right  <= head.r;
            end else begin
              state           <= ST_PREFILL;
              sample_left     <= '0;
              sample_right    <= '0;
              underrun_sticky <= 1'b1;
              if (ucount != 8'hFF) ucount <= ucount + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= ST_PREFILL;
      endcase
    end
  end

`ifdef AUDIO_I2S_EN
  frame_t ser_frame;

  assign ser_frame = pop ? head : '0;

  audio_i2s_serializer u_i2s (
    .clk   (clk),
    .reset (reset),
    .start (frame_fire),
    .frame (ser_frame),
    .bclk  (i2s_bclk),
    .lrclk (i2s_lrclk),
    .sdata (i2s_sdata)
  );
`else
  assign i2s_bclk  = 1'b0;
  assign i2s_lrclk = 1'b0;
  assign i2s_sdata = 1'b0;
`endif

endmodule
